swipt_frame_link: RTL and testbench

//  Parametrised half-duplex frame link for the SWIPT data channel. Accepts a (mode,type,payload) request,

---
 rtl/swipt_link_pkg.sv | 30 +++
 rtl/swipt_frame_link_if.sv | 23 ++
 rtl/swipt_frame_link_serializer.sv | 59 +++++
 rtl/swipt_frame_link.sv | 212 +++++++++++++++++++++
 tb/tb_swipt_frame_link.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/swipt_link_pkg.sv
// Shared constants, FSM states, response codes and frame helpers for the SWIPT frame link.
package swipt_link_pkg;

  localparam logic [5:0] PREAMBLE = 6'b101010;
  localparam logic [3:0] TRAILER  = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TX     = 2'b01,
    ST_BLIND  = 2'b10,
    ST_LISTEN = 2'b11
  } link_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_SUM_ERR = 2'b01,
    RSP_TIMEOUT = 2'b10,
    RSP_ABORT   = 2'b11
  } rsp_status_e;

  function automatic int frame_w(input int data_w);
    return 15 + data_w;
  endfunction

  // Payloads narrower than 32 bits are zero-extended, which leaves XOR parity unchanged.
  function automatic logic parity32(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/swipt_frame_link_if.sv
// Request/response handshake between the controller-side request source and the SWIPT frame link.
interface swipt_frame_link_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_mode;
  logic [1:0]        req_type;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_mode, req_type, req_data,
    input  req_ready, rsp_valid, rsp_status, rsp_data
  );

  modport slave (
    input  req_valid, req_mode, req_type, req_data,
    output req_ready, rsp_valid, rsp_status, rsp_data
  );
endinterface

// File: rtl/swipt_frame_link_serializer.sv
// swipt_frame_serializer: holds a loaded frame and shifts it out MSB first, one bit every BIT_CYC cycles.
module swipt_frame_serializer #(
  parameter int FRAME_W = 23,
  parameter int BIT_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_dout,
  output logic               o_busy,
  output logic               o_last
);
  localparam int BCW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int IDW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYC - 1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(FRAME_W - 1);

  logic [FRAME_W-1:0] r_shift;
  logic [BCW-1:0]     r_bit_cnt;
  logic [IDW-1:0]     r_idx;
  logic               r_busy;
  logic               w_period_end;

  assign w_period_end = r_busy && (r_bit_cnt == BIT_LAST);
  assign o_last       = w_period_end && (r_idx == IDX_LAST);
  assign o_dout       = r_shift[FRAME_W-1];
  assign o_busy       = r_busy;

  // Bit-period timer, bit index and shift register; the shifter is zeroed after the last bit so dout idles low.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
    end else if (i_load) begin
      r_shift   <= i_frame;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b1;
    end else if (o_last) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
    end else if (w_period_end) begin
      r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
      r_bit_cnt <= '0;
      r_idx     <= r_idx + 1'b1;
      r_busy    <= 1'b1;
    end else if (r_busy) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end else begin
      r_bit_cnt <= '0;
    end
  end
endmodule

// File: rtl/swipt_frame_link.sv
// swipt_frame_link: half-duplex request/response frame link for the SWIPT data channel.
// Optional automatic retransmission on TIMEOUT/SUM_ERR is enabled by defining SWIPT_LINK_RETRY_EN.
module swipt_frame_link
  import swipt_link_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_CYC   = 200000,
  parameter int BLIND_CYC = 1000000,
  parameter int RESP_CYC  = 10000000,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swiptAlive,
  input  logic              data_start,
  swipt_frame_link_if.slave bus,
  output logic              dout,
  output logic              write,
  output logic              read,
  output logic              rx_en,
  output logic              getMeanCurrent,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_sum_ok
);
  localparam int FRAME_W = frame_w(DATA_W);
  localparam int BLW = (BLIND_CYC > 1) ? $clog2(BLIND_CYC) : 1;
  localparam int RSW = (RESP_CYC > 1) ? $clog2(RESP_CYC) : 1;
  localparam logic [BLW-1:0] BLIND_LAST = BLW'(BLIND_CYC - 1);
  localparam logic [RSW-1:0] RESP_LAST  = RSW'(RESP_CYC - 1);

  if ((DATA_W < 1) || (DATA_W > 32) || (BIT_CYC < 2) || (BLIND_CYC < 1) ||
      (RESP_CYC < 1) || (MAX_RETRY < 0)) begin : g_bad_param
    $error("swipt_frame_link: parameter out of range");
  end

  link_state_e        r_state, w_state_nxt;
  rsp_status_e        r_status, w_status_nxt, w_outcome;
  logic               r_read, r_rx_en, r_gmc, r_rsp_valid;
  logic               w_read_nxt, w_rx_en_nxt, w_gmc_nxt, w_valid_nxt;
  logic [DATA_W-1:0]  r_rsp_data, w_data_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt, w_frame_new;
  logic [BLW-1:0]     r_blind_cnt;
  logic [RSW-1:0]     r_win_cnt;
  logic               w_alive, w_ready, w_accept, w_ser_load, w_ser_clear, w_tx_last;
`ifdef SWIPT_LINK_RETRY_EN
  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTW-1:0] RETRY_LIMIT = RTW'(MAX_RETRY);
  logic [RTW-1:0]     r_retry_cnt, w_retry_nxt;
`endif

  assign w_alive     = swiptAlive && data_start;
  assign w_ready     = (r_state == ST_IDLE) && w_alive;
  assign w_accept    = bus.req_valid && w_ready;
  assign w_frame_new = {PREAMBLE, bus.req_mode, bus.req_type, bus.req_data,
                        parity32(32'(bus.req_data)), TRAILER};

  assign bus.req_ready  = w_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_status;
  assign bus.rsp_data   = r_rsp_data;
  assign read           = r_read;
  assign rx_en          = r_rx_en;
  assign getMeanCurrent = r_gmc;

  swipt_frame_serializer #(.FRAME_W(FRAME_W), .BIT_CYC(BIT_CYC)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ser_load),
    .i_clear(w_ser_clear),
    .i_frame(w_frame_nxt),
    .o_dout (dout),
    .o_busy (write),
    .o_last (w_tx_last)
  );

  // Next-state and next-output decode; an abort outranks every in-flight event.
  always_comb begin
    w_state_nxt  = r_state;
    w_read_nxt   = r_read;
    w_rx_en_nxt  = r_rx_en;
    w_gmc_nxt    = 1'b0;
    w_valid_nxt  = 1'b0;
    w_status_nxt = r_status;
    w_data_nxt   = r_rsp_data;
    w_frame_nxt  = r_frame;
    w_ser_load   = 1'b0;
    w_ser_clear  = 1'b0;
    w_outcome    = RSP_TIMEOUT;
`ifdef SWIPT_LINK_RETRY_EN
    w_retry_nxt  = r_retry_cnt;
`endif
    if ((r_state != ST_IDLE) && !w_alive) begin
      w_state_nxt  = ST_IDLE;
      w_read_nxt   = 1'b0;
      w_rx_en_nxt  = 1'b0;
      w_ser_clear  = 1'b1;
      w_valid_nxt  = 1'b1;
      w_status_nxt = RSP_ABORT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = ST_TX;
            w_frame_nxt = w_frame_new;
            w_ser_load  = 1'b1;
`ifdef SWIPT_LINK_RETRY_EN
            w_retry_nxt = '0;
`endif
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_TX: begin
          if (w_tx_last) begin
            w_state_nxt = ST_BLIND;
            w_read_nxt  = 1'b1;
            w_gmc_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_TX;
          end
        end
        ST_BLIND: begin
          if (r_blind_cnt == BLIND_LAST) begin
            w_state_nxt = ST_LISTEN;
            w_rx_en_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_BLIND;
          end
        end
        ST_LISTEN: begin
          if (rx_done || (r_win_cnt == RESP_LAST)) begin
            if (rx_done) begin
              w_data_nxt = rx_data;
              w_outcome  = rx_sum_ok ? RSP_OK : RSP_SUM_ERR;
            end else begin
              w_outcome  = RSP_TIMEOUT;
            end
            w_read_nxt  = 1'b0;
            w_rx_en_nxt = 1'b0;
`ifdef SWIPT_LINK_RETRY_EN
            if ((w_outcome != RSP_OK) && (r_retry_cnt < RETRY_LIMIT)) begin
              w_retry_nxt = r_retry_cnt + 1'b1;
              w_state_nxt = ST_TX;
              w_ser_load  = 1'b1;
            end else begin
              w_state_nxt  = ST_IDLE;
              w_valid_nxt  = 1'b1;
              w_status_nxt = w_outcome;
            end
`else
            w_state_nxt  = ST_IDLE;
            w_valid_nxt  = 1'b1;
            w_status_nxt = w_outcome;
`endif
          end else begin
            w_state_nxt = ST_LISTEN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_read_nxt  = 1'b0;
          w_rx_en_nxt = 1'b0;
          w_ser_clear = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_status    <= RSP_OK;
      r_read      <= 1'b0;
      r_rx_en     <= 1'b0;
      r_gmc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_frame     <= '0;
`ifdef SWIPT_LINK_RETRY_EN
      r_retry_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_status    <= w_status_nxt;
      r_read      <= w_read_nxt;
      r_rx_en     <= w_rx_en_nxt;
      r_gmc       <= w_gmc_nxt;
      r_rsp_valid <= w_valid_nxt;
      r_rsp_data  <= w_data_nxt;
      r_frame     <= w_frame_nxt;
`ifdef SWIPT_LINK_RETRY_EN
      r_retry_cnt <= w_retry_nxt;
`endif
    end
  end

  // Blind and listen-window timers run only while their state is active.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_BLIND)) begin
      r_blind_cnt <= '0;
    end else begin
      r_blind_cnt <= r_blind_cnt + 1'b1;
    end
    if (rst || (r_state != ST_LISTEN)) begin
      r_win_cnt <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_swipt_frame_link.sv
// Directed table-driven bench for swipt_frame_link (DATA_W=8, BIT_CYC=4, BLIND_CYC=5, RESP_CYC=20, MAX_RETRY=2).
module tb_swipt_frame_link;
  localparam int DATA_W    = 8;
  localparam int BIT_CYC   = 4;
  localparam int BLIND_CYC = 5;
  localparam int RESP_CYC  = 20;
  localparam int MAX_RETRY = 2;
  localparam int TX_CYC    = 23 * BIT_CYC;
`ifdef SWIPT_LINK_RETRY_EN
  localparam int ATTEMPTS_ON_FAIL = MAX_RETRY + 1;
`else
  localparam int ATTEMPTS_ON_FAIL = 1;
`endif

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  typ;
    logic [7:0]  data;
    logic [22:0] exp_frame;
    int          rx_at;
    logic [7:0]  rx_val;
    logic        sum_ok;
    logic [1:0]  exp_status;
    logic [7:0]  exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, swiptAlive, data_start;
  logic       dout, write, read, rx_en, gmc;
  logic       rx_done, rx_sum_ok;
  logic [7:0] rx_data;
  int         n_tests = 0;
  int         n_fail  = 0;
  vec_t       vecs[4];

  swipt_frame_link_if #(.DATA_W(DATA_W)) bus ();

  swipt_frame_link #(
    .DATA_W(DATA_W), .BIT_CYC(BIT_CYC), .BLIND_CYC(BLIND_CYC),
    .RESP_CYC(RESP_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .swiptAlive(swiptAlive), .data_start(data_start),
    .bus(bus), .dout(dout), .write(write), .read(read), .rx_en(rx_en),
    .getMeanCurrent(gmc), .rx_done(rx_done), .rx_data(rx_data), .rx_sum_ok(rx_sum_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [1:0] m, input logic [1:0] t, input logic [7:0] d, input string tag);
    bus.req_mode  = m;
    bus.req_type  = t;
    bus.req_data  = d;
    bus.req_valid = 1'b1;
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Starts at TX cycle 0 and returns at LISTEN cycle 0.
  task automatic run_frame(input logic [22:0] exp, input string tag);
    logic [22:0] got;
    logic        hold_bad;
    int          wr_cnt;
    got = '0;
    hold_bad = 1'b0;
    wr_cnt = 0;
    for (int j = 0; j < TX_CYC; j++) begin
      if ((j % BIT_CYC) == 0) got[22 - j / BIT_CYC] = dout;
      else if (dout !== got[22 - j / BIT_CYC]) hold_bad = 1'b1;
      if (write === 1'b1) wr_cnt++;
      tick();
    end
    check({tag, " frame"}, 32'(got), 32'(exp));
    check({tag, " bit hold"}, 32'(hold_bad), 32'd0);
    check({tag, " write cycles"}, 32'(wr_cnt), 32'(TX_CYC));
    check({tag, " blind write"}, 32'(write), 32'd0);
    check({tag, " blind read"}, 32'(read), 32'd1);
    check({tag, " blind gmc"}, 32'(gmc), 32'd1);
    check({tag, " blind rx_en"}, 32'(rx_en), 32'd0);
    tick();
    check({tag, " gmc pulse"}, 32'(gmc), 32'd0);
    repeat (BLIND_CYC - 2) tick();
    check({tag, " blind end rx_en"}, 32'(rx_en), 32'd0);
    tick();
    check({tag, " listen rx_en"}, 32'(rx_en), 32'd1);
    check({tag, " listen read"}, 32'(read), 32'd1);
  endtask

  // Walks the listen window, optionally pulsing rx_done at window cycle rx_at.
  task automatic run_listen(input int rx_at, input logic [7:0] rxd, input logic ok, input string tag);
    logic win_bad;
    win_bad = 1'b0;
    for (int w = 0; w < RESP_CYC; w++) begin
      if ((rx_en !== 1'b1) || (bus.rsp_valid !== 1'b0)) win_bad = 1'b1;
      if (w == rx_at) begin
        rx_done   = 1'b1;
        rx_data   = rxd;
        rx_sum_ok = ok;
      end
      tick();
      rx_done = 1'b0;
      if (w == rx_at) break;
    end
    check({tag, " window steady"}, 32'(win_bad), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b00, 2'b11, 8'hA5, 23'b10101000111010010100101, 3,  8'h3C, 1'b1, 2'b00, 8'h3C};
    vecs[1] = '{2'b01, 2'b10, 8'h07, 23'b10101001100000011110101, -1, 8'h00, 1'b0, 2'b10, 8'h3C};
    vecs[2] = '{2'b10, 2'b01, 8'hFF, 23'b10101010011111111100101, 19, 8'h5A, 1'b0, 2'b01, 8'h5A};
    vecs[3] = '{2'b11, 2'b00, 8'h81, 23'b10101011001000000100101, 0,  8'hC3, 1'b1, 2'b00, 8'hC3};

    rst = 1'b1; swiptAlive = 1'b1; data_start = 1'b1;
    rx_done = 1'b0; rx_data = 8'h00; rx_sum_ok = 1'b0;
    bus.req_valid = 1'b0; bus.req_mode = 2'b00; bus.req_type = 2'b00; bus.req_data = 8'h00;
    repeat (3) tick();
    check("reset dout", 32'(dout), 32'd0);
    check("reset write", 32'(write), 32'd0);
    check("reset read", 32'(read), 32'd0);
    check("reset rx_en", 32'(rx_en), 32'd0);
    check("reset gmc", 32'(gmc), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_status", 32'(bus.rsp_status), 32'd0);
    check("reset rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0;
    tick();
    check("idle req_ready", 32'(bus.req_ready), 32'd1);

    swiptAlive = 1'b0;
    #1;
    check("dead req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("idle drop no pulse", 32'(bus.rsp_valid), 32'd0);
    swiptAlive = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      string tag;
      int    n_att;
      tag = $sformatf("v%0d", v);
      n_att = (vecs[v].exp_status != 2'b00) ? ATTEMPTS_ON_FAIL : 1;
      send_req(vecs[v].mode, vecs[v].typ, vecs[v].data, tag);
      for (int a = 0; a < n_att; a++) begin
        run_frame(vecs[v].exp_frame, tag);
        run_listen(vecs[v].rx_at, vecs[v].rx_val, vecs[v].sum_ok, tag);
        if (a == n_att - 1) begin
          check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
          check({tag, " rsp_status"}, 32'(bus.rsp_status), 32'(vecs[v].exp_status));
          check({tag, " rsp_data"}, 32'(bus.rsp_data), 32'(vecs[v].exp_data));
          check({tag, " done rx_en"}, 32'(rx_en), 32'd0);
          check({tag, " done read"}, 32'(read), 32'd0);
        end else begin
          check({tag, " retry no rsp"}, 32'(bus.rsp_valid), 32'd0);
          check({tag, " retry write"}, 32'(write), 32'd1);
        end
      end
      tick();
      check({tag, " rsp pulse width"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, " ready again"}, 32'(bus.req_ready), 32'd1);
    end

    // Abort in the middle of TX bit 10.
    send_req(2'b00, 2'b11, 8'hA5, "abort");
    repeat (41) tick();
    check("abort pre dout", 32'(dout), 32'd1);
    check("abort pre write", 32'(write), 32'd1);
    data_start = 1'b0;
    tick();
    check("abort dout", 32'(dout), 32'd0);
    check("abort write", 32'(write), 32'd0);
    check("abort read", 32'(read), 32'd0);
    check("abort rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("abort rsp_status", 32'(bus.rsp_status), 32'd3);
    check("abort rsp_data", 32'(bus.rsp_data), 32'hC3);
    data_start = 1'b1;
    tick();
    check("abort pulse width", 32'(bus.rsp_valid), 32'd0);
    check("abort ready", 32'(bus.req_ready), 32'd1);

    // New request after abort, then reset while listening.
    send_req(2'b01, 2'b10, 8'h07, "post");
    run_frame(vecs[1].exp_frame, "post");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst dout", 32'(dout), 32'd0);
    check("rst write", 32'(write), 32'd0);
    check("rst read", 32'(read), 32'd0);
    check("rst rx_en", 32'(rx_en), 32'd0);
    check("rst gmc", 32'(gmc), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_status", 32'(bus.rsp_status), 32'd0);
    check("rst rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b0;
    tick();
    check("rst release no pulse", 32'(bus.rsp_valid), 32'd0);
    check("rst release ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
